sseg_mux_ctrl: RTL and testbench
================================

# sseg_mux_ctrl

Parametrised seven-segment display controller: accepts binary words over a valid/ready handshake, converts them to BCD with a sequential shift-add-3 engine, and time-multiplexes DIGITS digits onto shared segment lines. Adds leading-zero blanking, per-digit decimal points, overflow indication and selectable output polarity. Sits between the measurement/stream-receive path and the board display pins.

## Interface
- DIGITS, 8, number of display digits (2..8)
- BIN_W, 32, binary input width (8..32)
- REFRESH_DIV, 100000, clk cycles each digit stays lit (>=2)
- ACTIVE_LOW, 1, 1: `sseg`/`dp`/`an` active-low; 0: active-high
- BLANK_LZ, 1, 1: enable leading-zero blanking

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_data  in  BIN_W  unsigned value to display
- in_dp  in  DIGITS  decimal-point mask, bit i lights dp of digit i (digit 0 = rightmost)
- in_valid  in  1  in_data/in_dp valid
- in_ready  out  1  controller can accept a word
- ovf  out  1  displayed value overflowed DIGITS decimal digits
- sseg  out  7  segments, bit0=a … bit6=g
- dp  out  1  decimal point
- an  out  DIGITS  digit enables, one-hot when lit

## Operation
- One clock; reset is synchronous and active-high. All outputs registered.
- FSM IDLE -> CONV -> LOAD -> IDLE.
  - IDLE: in_ready=1. On in_valid&&in_ready: latch in_data into shift reg, in_dp into dp_pend, clear BCD accumulator and sticky ovf_pend, go CONV.
  - CONV: BIN_W cycles, bit counter BIN_W-1..0. Each cycle: every BCD digit >=5 gets +3, then {bcd, shift} shifted left one bit. If the bit shifted out of the top digit is 1, set ovf_pend (sticky). in_ready=0.
  - LOAD: one cycle; copy BCD -> display reg, dp_pend -> dp reg, ovf_pend -> ovf. Go IDLE.
- in_valid outside IDLE is ignored (no handshake); no queueing.
- Display reg holds previous value throughout CONV.
- Digit scan: refresh counter 0..REFRESH_DIV-1; on terminal count, digit index advances 0..DIGITS-1, wraps to 0.
- Glyph for current digit i:
  - ovf=1: segment g only ("-") on every digit, dp off.
  - BLANK_LZ=1, i>0, digit i and all higher digits zero: all segments off, dp from mask.
  - else standard hex-decoder pattern for 0-9 (0 = a..f; 1 = b,c; 7 = a,b,c; 8 = all).
- Polarity: when ACTIVE_LOW=1 invert `sseg`, `dp`, `an` at the output register.

## Timing
- Reset values: in_ready=0 during reset, 1 from first cycle after; FSM=IDLE; display reg=0; dp reg=0; ovf=0; refresh counter=0; digit index=0; `an`, `sseg`, `dp` all inactive (all 1s when ACTIVE_LOW).
- First cycle after reset release: index 0 selected; `an`/`sseg` reflect digit 0 glyph "0" one cycle later.
- Conversion latency: handshake at cycle T -> display reg/ovf updated at end of cycle T+BIN_W+1; in_ready high again at T+BIN_W+2.
- Throughput: one word per BIN_W+2 cycles max.
- `an`/`sseg`/`dp` change one cycle after the digit index changes; new display value visible on the next scanned digit (no scan restart).
- Reset mid-CONV: conversion aborted, display cleared to 0, ovf=0.
- Value exactly 10^DIGITS-1: no overflow; 10^DIGITS: ovf=1.

## Test plan
- DIGITS=4, BIN_W=16, REFRESH_DIV=4: after reset, send 1234 -> in_ready low 17 cycles; scan shows 4,3,2,1 on an[0..3], each digit lit 4 cycles, ovf=0.
- Send 7 with BLANK_LZ=1 -> digit 0 shows "7", digits 1-3 blank; with BLANK_LZ=0 -> "0007"; send 0 -> digit 0 shows "0", others blank.
- Send 9999 -> "9999", ovf=0; send 10000 -> all digits "-", ovf=1; send 42 -> ovf clears, "42".
- Send 5 with in_dp=4'b0100 -> dp lit only while an[2] active, even though digit 2 is blanked.
- Hold in_valid during CONV with 3210 then 999 -> only 3210 accepted; 999 accepted on first IDLE cycle, displayed 18 cycles later.
- Assert rst at CONV cycle 8 of 1234 -> outputs to reset values next cycle; after release digit 0 shows "0", ovf=0; ACTIVE_LOW=0 run checks inverted polarity of all three outputs.

Source files
------------

// File: rtl/sseg_mux_ctrl_if.sv
// Word-input handshake bundle for the seven-segment controller; the producer
// holds in_data/in_dp/in_valid until in_ready is seen high at a clock edge.
interface sseg_mux_ctrl_if #(
    parameter int BIN_W  = 32,
    parameter int DIGITS = 8
);
    logic [BIN_W-1:0]  in_data;
    logic [DIGITS-1:0] in_dp;
    logic              in_valid;
    logic              in_ready;

    modport master (output in_data, in_dp, in_valid, input in_ready);
    modport slave  (input in_data, in_dp, in_valid, output in_ready);
endinterface

// File: rtl/sseg_mux_ctrl.sv
// Binary->BCD (shift-add-3) plus multiplexed seven-segment scan; BIN_W+2 cycles per word,
// in_ready low while converting, words offered meanwhile are not taken (no queueing).
module sseg_mux_ctrl #(
    parameter int DIGITS      = 8,
    parameter int BIN_W       = 32,
    parameter int REFRESH_DIV = 100000,
    parameter bit ACTIVE_LOW  = 1,
    parameter bit BLANK_LZ    = 1
) (
    input  logic              clk,
    input  logic              rst,
    sseg_mux_ctrl_if.slave    bus,
    output logic              ovf,
    output logic [6:0]        sseg,
    output logic              dp,
    output logic [DIGITS-1:0] an
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_W);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(DIGITS);
    localparam logic [CW-1:0] CNT_TOP  = CW'(BIN_W - 1);
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

    state_t            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic [BIN_W-1:0]  shift_q, shift_d;
    logic [BW-1:0]     bcd_q, bcd_d, bcd_adj;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              ovf_pend_q, ovf_pend_d;
    logic [DIGITS-1:0] dp_pend_q, dp_pend_d;
    logic [BW-1:0]     disp_q, disp_d;
    logic [DIGITS-1:0] dp_mask_q, dp_mask_d;
    logic              ovf_q, ovf_d;
    logic [RW-1:0]     ref_q, ref_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [6:0]        sseg_q, sseg_d;
    logic              dp_q, dp_d;
    logic [DIGITS-1:0] an_q, an_d;

    logic [DIGITS-1:0] upper_zero;
    logic [DIGITS-1:0] an_act;
    logic [3:0]        cur_dig;
    logic              cur_blank;
    logic              cur_dp;
    logic [6:0]        glyph;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        dp_pend_d  = dp_pend_q;
        disp_d     = disp_q;
        dp_mask_d  = dp_mask_q;
        ovf_d      = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    shift_d    = bus.in_data;
                    dp_pend_d  = bus.in_dp;
                    bcd_d      = '0;
                    ovf_pend_d = 1'b0;
                    cnt_d      = CNT_TOP;
                    state_d    = CONV;
                end
            end
            CONV: begin
                // A set MSB after adjust means a carry into a digit we don't have.
                {bcd_d, shift_d} = {bcd_adj[BW-2:0], shift_q, 1'b0};
                if (bcd_adj[BW-1]) begin
                    ovf_pend_d = 1'b1;
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                disp_d    = bcd_q;
                dp_mask_d = dp_pend_q;
                ovf_d     = ovf_pend_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == IDLE);
    end

    always_comb begin
        ref_d = ref_q + 1'b1;
        idx_d = idx_q;
        if (ref_q == REF_LAST) begin
            ref_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    always_comb begin
        upper_zero = '0;
        an_act     = '0;
        cur_dig    = '0;
        cur_blank  = 1'b0;
        cur_dp     = 1'b0;
        glyph      = 7'h00;
        for (int i = 0; i < DIGITS; i++) begin
            upper_zero[i] = ((disp_q >> (4 * i)) == '0);
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_dig   = disp_q[4*i +: 4];
                cur_blank = BLANK_LZ && (i > 0) && upper_zero[i];
                cur_dp    = dp_mask_q[i];
                an_act[i] = 1'b1;
            end
        end
        case (cur_dig)
            4'd0:    glyph = 7'h3F;
            4'd1:    glyph = 7'h06;
            4'd2:    glyph = 7'h5B;
            4'd3:    glyph = 7'h4F;
            4'd4:    glyph = 7'h66;
            4'd5:    glyph = 7'h6D;
            4'd6:    glyph = 7'h7D;
            4'd7:    glyph = 7'h07;
            4'd8:    glyph = 7'h7F;
            4'd9:    glyph = 7'h6F;
            default: glyph = 7'h00;
        endcase
        if (ovf_q) begin
            glyph  = 7'h40;
            cur_dp = 1'b0;
        end else if (cur_blank) begin
            glyph = 7'h00;
        end
        sseg_d = glyph ^ {7{ACTIVE_LOW}};
        dp_d   = cur_dp ^ ACTIVE_LOW;
        an_d   = an_act ^ {DIGITS{ACTIVE_LOW}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b0;
            shift_q    <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            dp_pend_q  <= '0;
            disp_q     <= '0;
            dp_mask_q  <= '0;
            ovf_q      <= 1'b0;
            ref_q      <= '0;
            idx_q      <= '0;
            sseg_q     <= {7{ACTIVE_LOW}};
            dp_q       <= ACTIVE_LOW;
            an_q       <= {DIGITS{ACTIVE_LOW}};
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            shift_q    <= shift_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            dp_pend_q  <= dp_pend_d;
            disp_q     <= disp_d;
            dp_mask_q  <= dp_mask_d;
            ovf_q      <= ovf_d;
            ref_q      <= ref_d;
            idx_q      <= idx_d;
            sseg_q     <= sseg_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
        end
    end

    assign bus.in_ready = in_ready_q;
    assign ovf          = ovf_q;
    assign sseg         = sseg_q;
    assign dp           = dp_q;
    assign an           = an_q;
endmodule

// File: tb/tb_sseg_mux_ctrl.sv
// Drives an active-low/blanking instance and an active-high/no-blanking instance with the
// same words; a decimal reference model scores every scanned digit.
module tb_sseg_mux_ctrl;
    localparam int DIGITS      = 4;
    localparam int BIN_W       = 16;
    localparam int REFRESH_DIV = 4;

    typedef struct {
        int         val;
        logic [3:0] dpm;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sseg_mux_ctrl_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus_a ();
    sseg_mux_ctrl_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus_b ();

    logic       ovf_a, ovf_b, dp_a, dp_b;
    logic [6:0] sseg_a, sseg_b;
    logic [3:0] an_a, an_b;

    sseg_mux_ctrl #(.DIGITS(DIGITS), .BIN_W(BIN_W), .REFRESH_DIV(REFRESH_DIV),
                    .ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a), .ovf(ovf_a), .sseg(sseg_a), .dp(dp_a), .an(an_a));

    sseg_mux_ctrl #(.DIGITS(DIGITS), .BIN_W(BIN_W), .REFRESH_DIV(REFRESH_DIV),
                    .ACTIVE_LOW(1'b0), .BLANK_LZ(1'b0)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b), .ovf(ovf_b), .sseg(sseg_b), .dp(dp_b), .an(an_b));

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // Returns {dp, g..a}, active-high.
    function automatic logic [7:0] exp_glyph(input int val, input logic [3:0] m,
                                             input int k, input bit blank_en);
        int p = 1;
        for (int j = 0; j < k; j++) p = p * 10;
        if (val >= 10000) return 8'h40;
        if (blank_en && k > 0 && val < p) return {m[k], 7'h00};
        return {m[k], seg_of((val / p) % 10)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input int v, input logic [3:0] m, input logic vld);
        bus_a.in_data  = 16'(v);
        bus_a.in_dp    = m;
        bus_a.in_valid = vld;
        bus_b.in_data  = 16'(v);
        bus_b.in_dp    = m;
        bus_b.in_valid = vld;
    endtask

    task automatic push_exp(input int v, input logic [3:0] m);
        exp_t e;
        e.val = v;
        e.dpm = m;
        sb.push_back(e);
    endtask

    task automatic send(input int v, input logic [3:0] m);
        int n = 0;
        while (bus_a.in_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        chk("ready_wait", 32'(n < 100), 32'd1);
        drive(v, m, 1'b1);
        @(negedge clk);
        drive(v, m, 1'b0);
        push_exp(v, m);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (bus_a.in_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        chk(tag, n, BIN_W + 1);
    endtask

    task automatic cmp_digit(input string tag, input exp_t e, input int k);
        logic [7:0] ga, gb;
        logic [3:0] oh, an_exp;
        logic [6:0] seg_exp;
        logic       dp_exp;
        ga      = exp_glyph(e.val, e.dpm, k, 1'b1);
        gb      = exp_glyph(e.val, e.dpm, k, 1'b0);
        oh      = 4'(1 << k);
        an_exp  = ~oh;
        seg_exp = ~ga[6:0];
        dp_exp  = ~ga[7];
        chk($sformatf("%s_an_a%0d", tag, k), an_a, an_exp);
        chk($sformatf("%s_sseg_a%0d", tag, k), sseg_a, seg_exp);
        chk($sformatf("%s_dp_a%0d", tag, k), dp_a, dp_exp);
        chk($sformatf("%s_an_b%0d", tag, k), an_b, oh);
        chk($sformatf("%s_sseg_b%0d", tag, k), sseg_b, gb[6:0]);
        chk($sformatf("%s_dp_b%0d", tag, k), dp_b, gb[7]);
        chk($sformatf("%s_ovf_a%0d", tag, k), ovf_a, 32'(e.val >= 10000));
        chk($sformatf("%s_ovf_b%0d", tag, k), ovf_b, 32'(e.val >= 10000));
    endtask

    task automatic check_scan(input string tag);
        exp_t       e;
        int         n;
        logic [3:0] prev;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        @(negedge clk);
        n = 0;
        while (an_a === 4'b1110 && n < 40) begin @(negedge clk); n++; end
        n = 0;
        while (an_a !== 4'b1110 && n < 40) begin @(negedge clk); n++; end
        chk({tag, "_sync"}, 32'(n < 40), 32'd1);
        for (int k = 0; k < DIGITS; k++) begin
            cmp_digit(tag, e, k);
            prev = an_a;
            n = 0;
            do begin @(negedge clk); n++; end while (an_a === prev && n < 10);
            chk($sformatf("%s_lit%0d", tag, k), n, REFRESH_DIV);
        end
    endtask

    task automatic check_now(input string tag);
        exp_t e;
        int   k = -1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        for (int i = 0; i < DIGITS; i++) if (an_b[i] === 1'b1) k = i;
        chk({tag, "_lit"}, 32'(k >= 0), 32'd1);
        if (k >= 0) cmp_digit(tag, e, k);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, bus_a.in_ready, 32'd0);
        chk({tag, "_ready_b"}, bus_b.in_ready, 32'd0);
        chk({tag, "_an_a"}, an_a, 32'hF);
        chk({tag, "_sseg_a"}, sseg_a, 32'h7F);
        chk({tag, "_dp_a"}, dp_a, 32'd1);
        chk({tag, "_ovf_a"}, ovf_a, 32'd0);
        chk({tag, "_an_b"}, an_b, 32'h0);
        chk({tag, "_sseg_b"}, sseg_b, 32'h0);
        chk({tag, "_dp_b"}, dp_b, 32'd0);
        chk({tag, "_ovf_b"}, ovf_b, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(0, 4'b0000, 1'b0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", bus_a.in_ready, 32'd1);
        @(negedge clk);
        chk("post_rst_an_a", an_a, 32'hE);
        chk("post_rst_sseg_a", sseg_a, 32'h40);
        chk("post_rst_sseg_b", sseg_b, 32'h3F);

        send(1234, 4'b0000); wait_ready("busy_1234"); check_scan("v1234");
        send(7, 4'b0000);    wait_ready("busy_7");    check_scan("v7");
        send(0, 4'b0000);    wait_ready("busy_0");    check_scan("v0");
        send(9999, 4'b0000); wait_ready("busy_9999"); check_scan("v9999");
        send(10000, 4'b0000); wait_ready("busy_10000"); check_scan("v10000");
        send(42, 4'b0000);   wait_ready("busy_42");   check_scan("v42");
        send(5, 4'b0100);    wait_ready("busy_5dp");  check_scan("v5dp");

        // 999 is offered continuously while 3210 converts; it must wait for IDLE.
        send(3210, 4'b0000);
        drive(999, 4'b0000, 1'b1);
        wait_ready("busy_3210");
        @(negedge clk);
        drive(999, 4'b0000, 1'b0);
        check_now("v3210");
        push_exp(999, 4'b0000);
        wait_ready("busy_999");
        check_scan("v999");

        send(10000, 4'b1111); wait_ready("busy_ovf2"); check_scan("vovf2");

        send(1234, 4'b0000);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_conv_rst");
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("mid_rst_ready", bus_a.in_ready, 32'd1);
        push_exp(0, 4'b0000);
        check_scan("post_abort");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
